cpu_debug_sequencer: RTL and testbench

CPU_DEBUG_SEQUENCER -- requirements
Module: cpu_debug_sequencer

---
 rtl/cpu_debug_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_cpu_debug_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_sequencer.sv
`timescale 1ns/1ps
// Debug command sequencer: turns HALT/RUN/STEP/SNAPSHOT commands into single-beat
// accesses on the core's CSR slave port and returns result words on a valid/ready stream.
module cpu_debug_sequencer #(
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [31:0] i_cmd_arg,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_last,
  output logic        o_busy,
  output logic [6:0]  o_m_address,
  output logic        o_m_read,
  output logic        o_m_write,
  output logic [31:0] o_m_writedata,
  input  logic [31:0] i_m_readdata
);

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_SNAP = 2'b11;

  localparam logic [6:0] ADDR_CTRL  = 7'h08;
  localparam logic [6:0] ADDR_STEPS = 7'h0C;
  localparam logic [3:0] SNAP_LAST  = 4'd11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_POLL_RD,
    ST_POLL_CAP,
    ST_POLL_WAIT,
    ST_SNAP_RD,
    ST_SNAP_CAP,
    ST_RSP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_arg;
  logic [31:0] r_polls;
  logic [31:0] r_gap;
  logic [3:0]  r_word;
  logic [31:0] r_rsp_data;
  logic        r_rsp_last;
  logic        w_rsp_load;
  logic [31:0] w_rsp_data_nxt;
  logic        w_rsp_last_nxt;
  logic        w_run;

  assign w_run = !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rsp_load     = 1'b0;
    w_rsp_data_nxt = '0;
    w_rsp_last_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd_op)
            OP_SNAP: w_state_nxt = ST_SNAP_RD;
            OP_STEP: begin
              if (i_cmd_arg == '0) begin
                w_state_nxt    = ST_RSP;
                w_rsp_load     = 1'b1;
                w_rsp_last_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_WR_A;
              end
            end
            default: w_state_nxt = ST_WR_A;
          endcase
        end
      end
      ST_WR_A: begin
        if (r_op == OP_RUN) begin
          w_state_nxt    = ST_RSP;
          w_rsp_load     = 1'b1;
          w_rsp_last_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (r_op == OP_HALT) begin
          w_state_nxt    = ST_RSP;
          w_rsp_load     = 1'b1;
          w_rsp_last_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_POLL_RD;
        end
      end
      ST_POLL_RD: w_state_nxt = ST_POLL_CAP;
      // r_polls already counts the read whose data is being sampled here
      ST_POLL_CAP: begin
        if (i_m_readdata == '0) begin
          w_state_nxt    = ST_RSP;
          w_rsp_load     = 1'b1;
          w_rsp_data_nxt = r_polls;
          w_rsp_last_nxt = 1'b1;
        end else if (r_polls >= MAX_POLLS) begin
          w_state_nxt    = ST_RSP;
          w_rsp_load     = 1'b1;
          w_rsp_data_nxt = 32'hFFFF_FFFF;
          w_rsp_last_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        if (r_gap == POLL_GAP - 1) begin
          w_state_nxt = ST_POLL_RD;
        end
      end
      ST_SNAP_RD: w_state_nxt = ST_SNAP_CAP;
      ST_SNAP_CAP: begin
        w_state_nxt    = ST_RSP;
        w_rsp_load     = 1'b1;
        w_rsp_data_nxt = i_m_readdata;
        w_rsp_last_nxt = (r_word == SNAP_LAST);
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          if (r_op == OP_SNAP && !r_rsp_last) begin
            w_state_nxt = ST_SNAP_RD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op       <= OP_HALT;
      r_arg      <= '0;
      r_polls    <= '0;
      r_gap      <= '0;
      r_word     <= '0;
      r_rsp_data <= '0;
      r_rsp_last <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_cmd_valid) begin
        r_op    <= i_cmd_op;
        r_arg   <= i_cmd_arg;
        r_polls <= '0;
        r_word  <= '0;
      end
      if (r_state == ST_POLL_RD) begin
        r_polls <= r_polls + 32'd1;
      end
      if (r_state == ST_POLL_CAP) begin
        r_gap <= '0;
      end else if (r_state == ST_POLL_WAIT) begin
        r_gap <= r_gap + 32'd1;
      end
      // Only a non-final word advances the snapshot index
      if (r_state == ST_RSP && i_rsp_ready && !r_rsp_last) begin
        r_word <= r_word + 4'd1;
      end
      if (w_rsp_load) begin
        r_rsp_data <= w_rsp_data_nxt;
        r_rsp_last <= w_rsp_last_nxt;
      end
    end
  end

  // Outputs are forced low while reset is high so an aborted command emits nothing
  always_comb begin
    o_cmd_ready   = w_run && (r_state == ST_IDLE);
    o_busy        = w_run && (r_state != ST_IDLE);
    o_rsp_valid   = w_run && (r_state == ST_RSP);
    o_rsp_data    = '0;
    o_rsp_last    = 1'b0;
    o_m_read      = 1'b0;
    o_m_write     = 1'b0;
    o_m_address   = '0;
    o_m_writedata = '0;
    if (w_run) begin
      case (r_state)
        ST_WR_A: begin
          o_m_write     = 1'b1;
          o_m_address   = (r_op == OP_RUN) ? ADDR_CTRL : ADDR_STEPS;
          o_m_writedata = (r_op == OP_STEP) ? r_arg : 32'd0;
        end
        ST_WR_B: begin
          o_m_write     = 1'b1;
          o_m_address   = ADDR_CTRL;
          o_m_writedata = 32'd1;
        end
        ST_POLL_RD: begin
          o_m_read    = 1'b1;
          o_m_address = ADDR_STEPS;
        end
        ST_SNAP_RD: begin
          o_m_read    = 1'b1;
          o_m_address = {1'b0, r_word, 2'b00};
        end
        ST_RSP: begin
          o_rsp_data = r_rsp_data;
          o_rsp_last = r_rsp_last;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_sequencer.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for cpu_debug_sequencer: expected CSR accesses and
// response words come from a command-level model; a monitor pops and compares them.
module tb_cpu_debug_sequencer;

  localparam int POLL_GAP  = 4;
  localparam int MAX_POLLS = 8;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_SNAP = 2'b11;

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
    int          gap;
  } csr_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmdOp = 2'b00;
  logic [31:0] cmdArg = 32'd0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspData;
  logic        rspLast;
  logic        busy;
  logic [6:0]  mAddress;
  logic        mRead;
  logic        mWrite;
  logic [31:0] mWritedata;
  logic [31:0] mReaddata = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acceptCyc = -100;
  int lastStrobe = -100;
  int acceptCnt = 0;
  int doneCnt = 0;
  int abortCnt = 0;
  int readyMode = 0;
  int patIdx = 0;
  bit curStep = 1'b0;
  bit held = 1'b0;
  logic [31:0] heldData = 32'd0;
  logic        heldLast = 1'b0;
  logic [3:0]  readyPat = 4'b1001;
  logic [31:0] snapMem [0:31];
  logic [31:0] pollQ [$];
  csr_t        expCsr [$];
  rsp_t        expRsp [$];
  csr_t        monCsr;
  rsp_t        monRsp;

  cpu_debug_sequencer #(
    .POLL_GAP (POLL_GAP),
    .MAX_POLLS(MAX_POLLS)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cmd_valid  (cmdValid),
    .o_cmd_ready  (cmdReady),
    .i_cmd_op     (cmdOp),
    .i_cmd_arg    (cmdArg),
    .o_rsp_valid  (rspValid),
    .i_rsp_ready  (rspReady),
    .o_rsp_data   (rspData),
    .o_rsp_last   (rspLast),
    .o_busy       (busy),
    .o_m_address  (mAddress),
    .o_m_read     (mRead),
    .o_m_write    (mWrite),
    .o_m_writedata(mWritedata),
    .i_m_readdata (mReaddata)
  );

  // Free-running clock and cycle counter used for strobe spacing checks
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // CSR slave model: read data valid exactly in the cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    logic [31:0] val;
    if (mRead) begin
      if (curStep) begin
        val = (pollQ.size() != 0) ? pollQ.pop_front() : 32'd1;
      end else begin
        val = snapMem[mAddress[6:2]];
      end
      mReaddata <= val;
    end else begin
      mReaddata <= $urandom | 32'h1;
    end
  end

  // Consumer back-pressure: always ready, fixed 1-0-0-1 pattern, or random
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: rspReady = 1'b1;
      1: begin
        rspReady = readyPat[patIdx];
        patIdx = (patIdx + 1) % 4;
      end
      default: rspReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every CSR strobe and every transferred word against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (mRead || mWrite) begin
        checkOutput("strobe_exclusive", 32'(mRead & mWrite), 32'd0);
        if (expCsr.size() == 0) begin
          checkOutput("csr_unexpected_addr", 32'(mAddress), 32'hFFFF_FFFF);
        end else begin
          monCsr = expCsr.pop_front();
          checkOutput("csr_kind_write", 32'(mWrite), 32'(monCsr.wr));
          checkOutput("csr_addr", 32'(mAddress), 32'(monCsr.addr));
          if (monCsr.wr) checkOutput("csr_wdata", mWritedata, monCsr.data);
          if (monCsr.gap != 0) begin
            checkOutput("csr_gap", 32'(cyc - ((acceptCyc > lastStrobe) ? acceptCyc : lastStrobe)), 32'(monCsr.gap));
          end
        end
        lastStrobe = cyc;
      end
      if (acceptCnt != doneCnt + abortCnt) checkOutput("busy_high", 32'(busy), 32'd1);
      if (held) begin
        checkOutput("rsp_hold_valid", 32'(rspValid), 32'd1);
        checkOutput("rsp_hold_data", rspData, heldData);
        checkOutput("rsp_hold_last", 32'(rspLast), 32'(heldLast));
      end
      held = 1'b0;
      if (rspValid) begin
        if (rspReady) begin
          if (expRsp.size() == 0) begin
            checkOutput("rsp_unexpected_data", rspData, ~rspData);
          end else begin
            monRsp = expRsp.pop_front();
            checkOutput("rsp_data", rspData, monRsp.data);
            checkOutput("rsp_last", 32'(rspLast), 32'(monRsp.last));
          end
          if (rspLast) doneCnt++;
        end else begin
          held = 1'b1;
          heldData = rspData;
          heldLast = rspLast;
        end
      end
    end
  end

  task automatic pushCsr(input bit wr, input logic [6:0] addr, input logic [31:0] data, input int gap);
    csr_t c;
    c.wr = wr;
    c.addr = addr;
    c.data = data;
    c.gap = gap;
    expCsr.push_back(c);
  endtask

  task automatic pushRsp(input logic [31:0] data, input bit last);
    rsp_t r;
    r.data = data;
    r.last = last;
    expRsp.push_back(r);
  endtask

  // Builds the command's expected traffic from its definition, then issues it
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] arg, input int zeroAt,
                               input bit addrPattern, input bit waitDone);
    int n;
    bit found;
    int budget;
    int startDone;
    pollQ.delete();
    curStep = (op == OP_STEP);
    if (op == OP_STEP && arg != 0) begin
      for (int i = 0; i < MAX_POLLS; i++) begin
        if (zeroAt >= MAX_POLLS) pollQ.push_back(arg);
        else pollQ.push_back((i < zeroAt) ? 32'(zeroAt - i) : 32'd0);
      end
    end
    if (op == OP_SNAP) begin
      for (int i = 0; i < 12; i++) snapMem[i] = addrPattern ? 32'(i * 4 * 16) : $urandom;
    end
    case (op)
      OP_HALT: begin
        pushCsr(1'b1, 7'h0C, 32'd0, 1);
        pushCsr(1'b1, 7'h08, 32'd1, 1);
        pushRsp(32'd0, 1'b1);
      end
      OP_RUN: begin
        pushCsr(1'b1, 7'h08, 32'd0, 1);
        pushRsp(32'd0, 1'b1);
      end
      OP_STEP: begin
        if (arg == 0) begin
          pushRsp(32'd0, 1'b1);
        end else begin
          pushCsr(1'b1, 7'h0C, arg, 1);
          pushCsr(1'b1, 7'h08, 32'd1, 1);
          n = 0;
          found = 1'b0;
          while (n < MAX_POLLS && !found) begin
            pushCsr(1'b0, 7'h0C, 32'd0, (n == 0) ? 1 : POLL_GAP + 2);
            if (pollQ[n] == 0) found = 1'b1;
            n++;
          end
          pushRsp(found ? 32'(n) : 32'hFFFF_FFFF, 1'b1);
        end
      end
      default: begin
        for (int i = 0; i < 12; i++) begin
          pushCsr(1'b0, 7'(i * 4), 32'd0, (i == 0) ? 1 : 0);
          pushRsp(snapMem[i], i == 11);
        end
      end
    endcase

    @(posedge clk);
    #1;
    cmdOp = op;
    cmdArg = arg;
    cmdValid = 1'b1;
    for (budget = 0; budget < 50; budget++) begin
      @(negedge clk);
      if (cmdReady) break;
    end
    if (budget == 50) begin
      checkOutput("cmd_accept_timeout", 32'(cmdReady), 32'd1);
      cmdValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    cmdArg = $urandom;
    acceptCyc = cyc - 1;
    startDone = doneCnt;
    acceptCnt++;
    if (op == OP_STEP && arg == 0) checkOutput("step0_rsp_latency", 32'(rspValid), 32'd1);
    if (!waitDone) return;

    for (budget = 0; budget < 3000; budget++) begin
      @(posedge clk);
      #1;
      if (doneCnt != startDone) break;
    end
    if (budget == 3000) begin
      checkOutput("rsp_done_timeout", 32'(doneCnt - startDone), 32'd1);
      return;
    end
    checkOutput("idle_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("csr_all_seen", 32'(expCsr.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmdReady), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rspValid), 32'd0);
    checkOutput({tag, "_rsp_last"}, 32'(rspLast), 32'd0);
    checkOutput({tag, "_rsp_data"}, rspData, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_m_read"}, 32'(mRead), 32'd0);
    checkOutput({tag, "_m_write"}, 32'(mWrite), 32'd0);
    checkOutput({tag, "_m_address"}, 32'(mAddress), 32'd0);
    checkOutput({tag, "_m_writedata"}, mWritedata, 32'd0);
  endtask

  // Watchdog against a stuck simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    logic [1:0] op;
    logic [31:0] arg;
    for (int i = 0; i < 32; i++) snapMem[i] = 32'd0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    checkAllZero("reset");
    reset = 1'b0;
    #1;
    checkOutput("cmd_ready_after_reset", 32'(cmdReady), 32'd1);

    readyMode = 0;
    applyStimulus(OP_HALT, 32'd0, 0, 1'b0, 1'b1);
    applyStimulus(OP_RUN, 32'd0, 0, 1'b0, 1'b1);
    applyStimulus(OP_STEP, 32'd3, 2, 1'b0, 1'b1);
    applyStimulus(OP_STEP, 32'd5, MAX_POLLS, 1'b0, 1'b1);
    applyStimulus(OP_STEP, 32'd0, 0, 1'b0, 1'b1);
    readyMode = 1;
    applyStimulus(OP_SNAP, 32'd0, 0, 1'b1, 1'b1);

    readyMode = 2;
    for (int k = 0; k < 14; k++) begin
      op = 2'($urandom_range(0, 3));
      arg = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'h1);
      applyStimulus(op, arg, $urandom_range(0, MAX_POLLS), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Abort a snapshot in the cycle of its fifth read
    readyMode = 0;
    applyStimulus(OP_SNAP, 32'd0, 0, 1'b1, 1'b0);
    for (budget = 0; budget < 200; budget++) begin
      @(posedge clk);
      #1;
      if (mRead && mAddress == 7'h10) break;
    end
    if (budget == 200) checkOutput("snap5_read_timeout", 32'(mAddress), 32'h10);
    reset = 1'b1;
    expCsr.delete();
    expRsp.delete();
    pollQ.delete();
    abortCnt++;
    #1;
    checkAllZero("abort_same_cycle");
    @(posedge clk);
    #1;
    checkAllZero("abort_next_cycle");
    reset = 1'b0;
    #1;
    checkOutput("abort_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_rsp", 32'(rspValid), 32'd0);
      checkOutput("abort_no_strobe", 32'(mRead | mWrite), 32'd0);
    end

    applyStimulus(OP_HALT, 32'd0, 0, 1'b0, 1'b1);
    applyStimulus(OP_STEP, 32'd7, 0, 1'b0, 1'b1);
    checkOutput("rsp_all_seen", 32'(expRsp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
